// File: rtl/ex_pkg.sv
// Shared types and constants for the LEGv8-style execute stage.
//
// Contents:
//   alu_ctrl_e  - decoded ALU operation
//   ex_state_e  - execute-stage FSM state
//   OPC_*       - R-type opcode encodings (11 bits)
//   CTRL_*      - control-bundle width and bit positions
//   alu_decode  - main ALU-op + opcode to ALU operation
//
// Optional feature: EX_MUL_EN. When it is undefined, the MUL opcode decodes to ADD.
package ex_pkg;

    typedef enum logic [2:0] {
        AluAdd,
        AluSub,
        AluAnd,
        AluOrr,
        AluPassB,
        AluMul
    } alu_ctrl_e;

    typedef enum logic [0:0] {
        StIdle,
        StMul
    } ex_state_e;

    localparam logic [10:0] OPC_ADD = 11'b10001011000;
    localparam logic [10:0] OPC_SUB = 11'b11001011000;
    localparam logic [10:0] OPC_AND = 11'b10001010000;
    localparam logic [10:0] OPC_ORR = 11'b10101010000;
    localparam logic [10:0] OPC_MUL = 11'b10011011000;

    // ctrl bundle layout: {uncondbranch, branch, mem_read, mem_to_reg, mem_write, reg_write}
    localparam int unsigned CTRL_W          = 6;
    localparam int unsigned CTRL_UNCOND     = 5;
    localparam int unsigned CTRL_BRANCH     = 4;
    localparam int unsigned CTRL_MEM_READ   = 3;
    localparam int unsigned CTRL_MEM_TO_REG = 2;
    localparam int unsigned CTRL_MEM_WRITE  = 1;
    localparam int unsigned CTRL_REG_WRITE  = 0;

    function automatic alu_ctrl_e alu_decode(input logic [1:0] alu_op, input logic [10:0] opc);
        alu_ctrl_e c;
        c = AluAdd;
        case (alu_op)
            2'b01: c = AluPassB;
            2'b10: begin
                case (opc)
                    OPC_ADD: c = AluAdd;
                    OPC_SUB: c = AluSub;
                    OPC_AND: c = AluAnd;
                    OPC_ORR: c = AluOrr;
`ifdef EX_MUL_EN
                    OPC_MUL: c = AluMul;
`endif
                    default: c = AluAdd;
                endcase
            end
            default: c = AluAdd;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// Radix-2 shift-add multiplier returning the low WIDTH bits of a*b.
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - load operands and begin (restarts any operation in progress)
//   a, b       - multiplicand, multiplier (sampled on the start edge)
//   done       - high during the cycle whose closing edge performs the last step
//   product    - valid while done is high (includes that last step)
//
// One step per rising edge after the start edge, WIDTH steps in total, so a
// consumer registering product on the edge where done is high sees the result
// WIDTH cycles after start.
// Only instantiated when EX_MUL_EN is defined.
module ex_mul_iter
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;
    logic [CNT_W-1:0] cnt;
    logic             running;

    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign product  = acc_next;
    assign done     = running && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            acc     <= '0;
            mcand   <= a;
            mplier  <= b;
            cnt     <= '0;
            running <= 1'b1;
        end else if (running) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                running <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage_pipe.sv
// Execute stage between decode/register-read and memory, with a valid/ready
// handshake on both sides, synchronous flush and registered outputs.
//
// Ports:
//   clk, rst_n            - clock, asynchronous active-low reset
//   flush                 - drop the held / in-progress instruction
//   in_valid, in_ready    - upstream handshake
//   pc_in, imm_in         - instruction PC and sign-extended immediate
//   rs1_in, rs2_in        - register read data
//   opcode_in, alu_op_in  - opcode field and main-decoder ALU op
//   alu_src_in            - 1 selects imm_in as ALU operand B
//   ctrl_in, wr_reg_in    - control bundle and destination register
//   out_valid, out_ready  - downstream handshake
//   alu_result, zero      - ALU/MUL result and its zero flag
//   branch_target         - pc + (imm << BR_SHIFT)
//   store_data            - rs2 passthrough
//   ctrl_out, wr_reg      - registered ctrl_in / wr_reg_in
//   busy                  - multiplier iterating
//
// Optional feature: EX_MUL_EN adds an iterative multiplier (WIDTH-cycle MUL).
// Without it the MUL opcode executes as ADD and busy is tied low.
module ex_stage_pipe
    import ex_pkg::*;
#(
    parameter int unsigned WIDTH    = 64,
    parameter int unsigned BR_SHIFT = 2,
    parameter int unsigned OPC_W    = 11
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  pc_in,
    input  logic [WIDTH-1:0]  imm_in,
    input  logic [WIDTH-1:0]  rs1_in,
    input  logic [WIDTH-1:0]  rs2_in,
    input  logic [OPC_W-1:0]  opcode_in,
    input  logic [1:0]        alu_op_in,
    input  logic              alu_src_in,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [4:0]        wr_reg_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  alu_result,
    output logic              zero,
    output logic [WIDTH-1:0]  branch_target,
    output logic [WIDTH-1:0]  store_data,
    output logic [CTRL_W-1:0] ctrl_out,
    output logic [4:0]        wr_reg,
    output logic              busy
);

    ex_state_e        state;
    alu_ctrl_e        alu_ctrl;
    logic [10:0]      opc11;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] br_tgt;
    logic             accept;
    logic             is_mul;

    assign opc11    = 11'(opcode_in);
    assign alu_ctrl = alu_decode(alu_op_in, opc11);
    assign op_b     = alu_src_in ? imm_in : rs2_in;
    assign br_tgt   = pc_in + (imm_in << BR_SHIFT);

    // Empty or draining output register, and no flush, lets a new instruction in.
    assign in_ready = (state == StIdle) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        alu_res = rs1_in + op_b;
        case (alu_ctrl)
            AluSub:   alu_res = rs1_in - op_b;
            AluAnd:   alu_res = rs1_in & op_b;
            AluOrr:   alu_res = rs1_in | op_b;
            AluPassB: alu_res = op_b;
            default:  alu_res = rs1_in + op_b;
        endcase
    end

`ifdef EX_MUL_EN
    logic              mul_done;
    logic [WIDTH-1:0]  mul_product;
    logic [WIDTH-1:0]  pend_bt;
    logic [WIDTH-1:0]  pend_sd;
    logic [CTRL_W-1:0] pend_ctrl;
    logic [4:0]        pend_wr;

    assign is_mul = (alu_ctrl == AluMul);
    assign busy   = (state == StMul);

    ex_mul_iter #(
        .WIDTH(WIDTH)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (accept && is_mul),
        .a      (rs1_in),
        .b      (op_b),
        .done   (mul_done),
        .product(mul_product)
    );

    // Side-band fields held while the multiplier iterates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_bt   <= '0;
            pend_sd   <= '0;
            pend_ctrl <= '0;
            pend_wr   <= '0;
        end else if (accept && is_mul) begin
            pend_bt   <= br_tgt;
            pend_sd   <= rs2_in;
            pend_ctrl <= ctrl_in;
            pend_wr   <= wr_reg_in;
        end
    end
`else
    assign is_mul = 1'b0;
    assign busy   = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= StIdle;
            out_valid     <= 1'b0;
            alu_result    <= '0;
            zero          <= 1'b1;
            branch_target <= '0;
            store_data    <= '0;
            ctrl_out      <= '0;
            wr_reg        <= '0;
        end else if (flush) begin
            state     <= StIdle;
            out_valid <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (accept) begin
`ifdef EX_MUL_EN
                        if (is_mul) begin
                            state     <= StMul;
                            out_valid <= 1'b0;
                        end else
`endif
                        begin
                            out_valid     <= 1'b1;
                            alu_result    <= alu_res;
                            zero          <= (alu_res == '0);
                            branch_target <= br_tgt;
                            store_data    <= rs2_in;
                            ctrl_out      <= ctrl_in;
                            wr_reg        <= wr_reg_in;
                        end
                    end else if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
`ifdef EX_MUL_EN
                StMul: begin
                    if (mul_done) begin
                        state         <= StIdle;
                        out_valid     <= 1'b1;
                        alu_result    <= mul_product;
                        zero          <= (mul_product == '0);
                        branch_target <= pend_bt;
                        store_data    <= pend_sd;
                        ctrl_out      <= pend_ctrl;
                        wr_reg        <= pend_wr;
                    end
                end
`endif
                default: state <= StIdle;
            endcase
        end
    end

    logic unused_ok;
    assign unused_ok = is_mul;

endmodule

// File: tb/tb_ex_stage_pipe.sv
// Scoreboard bench for ex_stage_pipe (WIDTH=64). Expected results are pushed
// when an instruction is accepted; a monitor pops and compares whenever the
// DUT hands a result downstream. Works with and without EX_MUL_EN.
module tb_ex_stage_pipe;

    localparam logic [10:0] O_ADD = 11'b10001011000;
    localparam logic [10:0] O_SUB = 11'b11001011000;
    localparam logic [10:0] O_AND = 11'b10001010000;
    localparam logic [10:0] O_ORR = 11'b10101010000;
    localparam logic [10:0] O_MUL = 11'b10011011000;
    localparam logic [63:0] ALL1  = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef struct {
        string       tag;
        logic [63:0] res;
        logic        z;
        logic [63:0] bt;
        logic [63:0] sd;
        logic [5:0]  ctrl;
        logic [4:0]  wr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] pc_in, imm_in, rs1_in, rs2_in;
    logic [10:0] opcode_in;
    logic [1:0]  alu_op_in;
    logic        alu_src_in;
    logic [5:0]  ctrl_in;
    logic [4:0]  wr_reg_in;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] alu_result;
    logic        zero;
    logic [63:0] branch_target;
    logic [63:0] store_data;
    logic [5:0]  ctrl_out;
    logic [4:0]  wr_reg;
    logic        busy;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    ex_stage_pipe #(
        .WIDTH   (64),
        .BR_SHIFT(2),
        .OPC_W   (11)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .pc_in        (pc_in),
        .imm_in       (imm_in),
        .rs1_in       (rs1_in),
        .rs2_in       (rs2_in),
        .opcode_in    (opcode_in),
        .alu_op_in    (alu_op_in),
        .alu_src_in   (alu_src_in),
        .ctrl_in      (ctrl_in),
        .wr_reg_in    (wr_reg_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .alu_result   (alu_result),
        .zero         (zero),
        .branch_target(branch_target),
        .store_data   (store_data),
        .ctrl_out     (ctrl_out),
        .wr_reg       (wr_reg),
        .busy         (busy)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one instruction and hold it until accepted (bounded wait).
    task automatic issue(input string tag, input logic [63:0] pc, input logic [63:0] imm,
                         input logic [63:0] a, input logic [63:0] b, input logic [10:0] opc,
                         input logic [1:0] aop, input logic asrc, input logic [5:0] ctrl,
                         input logic [4:0] wr, input logic [63:0] res, input bit push);
        exp_t x;
        bit   ok;
        ok         = 1'b0;
        pc_in      = pc;
        imm_in     = imm;
        rs1_in     = a;
        rs2_in     = b;
        opcode_in  = opc;
        alu_op_in  = aop;
        alu_src_in = asrc;
        ctrl_in    = ctrl;
        wr_reg_in  = wr;
        in_valid   = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL %s.accept_timeout: got in_ready=0 for 200 cycles, expected 1", tag);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) begin
            x.tag  = tag;
            x.res  = res;
            x.z    = (res == 64'd0);
            x.bt   = pc + (imm << 2);
            x.sd   = b;
            x.ctrl = ctrl;
            x.wr   = wr;
            sb.push_back(x);
        end
        #1 in_valid = 1'b0;
    endtask

    // After a MUL accept: multi-cycle with the multiplier, single-cycle without.
    task automatic wait_mul(input string tag);
`ifdef EX_MUL_EN
        int busy_cycles;
        bit ready_seen;
        bit done_seen;
        busy_cycles = 0;
        ready_seen  = 1'b0;
        done_seen   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (out_valid) begin
                done_seen = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (in_ready) ready_seen = 1'b1;
        end
        check({tag, ".done_seen"}, 64'(done_seen), 64'd1);
        check({tag, ".busy_cycles"}, 64'(busy_cycles), 64'd64);
        check({tag, ".in_ready_while_busy"}, 64'(ready_seen), 64'd0);
        check({tag, ".busy_after_done"}, 64'(busy), 64'd0);
`else
        @(negedge clk);
        check({tag, ".latency1"}, 64'(out_valid), 64'd1);
`endif
    endtask

    // Monitor: compare every result handed downstream against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output",
                         alu_result);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, ".alu_result"}, alu_result, mon_e.res);
                check({mon_e.tag, ".zero"}, 64'(zero), 64'(mon_e.z));
                check({mon_e.tag, ".branch_target"}, branch_target, mon_e.bt);
                check({mon_e.tag, ".store_data"}, store_data, mon_e.sd);
                check({mon_e.tag, ".ctrl_out"}, 64'(ctrl_out), 64'(mon_e.ctrl));
                check({mon_e.tag, ".wr_reg"}, 64'(wr_reg), 64'(mon_e.wr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] mul_res;
        logic [63:0] mul_ovf_res;
        bit          drained;
`ifdef EX_MUL_EN
        mul_res     = 64'd42;
        mul_ovf_res = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        mul_res     = 64'd13;
        mul_ovf_res = 64'd1;
`endif
        rst_n      = 1'b0;
        flush      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        pc_in      = '0;
        imm_in     = '0;
        rs1_in     = '0;
        rs2_in     = '0;
        opcode_in  = '0;
        alu_op_in  = '0;
        alu_src_in = 1'b0;
        ctrl_in    = '0;
        wr_reg_in  = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.out_valid", 64'(out_valid), 64'd0);
        check("reset.busy", 64'(busy), 64'd0);
        check("reset.zero", 64'(zero), 64'd1);
        check("reset.alu_result", alu_result, 64'd0);
        check("reset.branch_target", branch_target, 64'd0);
        check("reset.store_data", store_data, 64'd0);
        check("reset.ctrl_out", 64'(ctrl_out), 64'd0);
        check("reset.wr_reg", 64'(wr_reg), 64'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 check("idle.in_ready", 64'(in_ready), 64'd1);

        // Single-cycle ALU ops, back to back.
        issue("add", 64'h40, 64'h10, 64'd5, 64'd7, O_ADD, 2'b10, 1'b0, 6'b000001, 5'd3,
              64'd12, 1'b1);
        @(negedge clk);
        check("add.latency1", 64'(out_valid), 64'd1);
        tick();
        issue("sub", 64'h100, 64'd3, 64'h1234, 64'h1234, O_SUB, 2'b10, 1'b0, 6'b000001, 5'd1,
              64'd0, 1'b1);
        issue("addi", 64'h200, 64'h20, 64'd100, 64'h55, 11'd0, 2'b00, 1'b1, 6'b001101, 5'd9,
              64'd132, 1'b1);
        issue("cbz", 64'h300, ALL1 - 64'd1, 64'd9, 64'd0, 11'd0, 2'b01, 1'b0, 6'b010000, 5'd0,
              64'd0, 1'b1);
        issue("and", 64'd0, 64'd0, 64'hFF00, 64'h0FF0, O_AND, 2'b10, 1'b0, 6'b000001, 5'd4,
              64'h0F00, 1'b1);
        issue("dflt", 64'd0, 64'd0, 64'd3, 64'd4, 11'h7FF, 2'b10, 1'b0, 6'b000001, 5'd5,
              64'd7, 1'b1);
        tick();

        // Backpressure: result held, stage not ready, then replace with no bubble.
        out_ready = 1'b0;
        issue("bp_add", 64'd0, 64'd0, 64'd1, 64'd2, O_ADD, 2'b00, 1'b0, 6'b000001, 5'd6,
              64'd3, 1'b1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp.in_ready", 64'(in_ready), 64'd0);
            check("bp.out_valid", 64'(out_valid), 64'd1);
            check("bp.alu_result_stable", alu_result, 64'd3);
        end
        tick();
        out_ready = 1'b1;
        issue("orr", 64'd0, 64'd0, 64'hF0, 64'h0F, O_ORR, 2'b10, 1'b0, 6'b000001, 5'd7,
              64'hFF, 1'b1);
        @(negedge clk);
        check("orr.no_gap", 64'(out_valid), 64'd1);
        tick();

        // MUL (iterative with the multiplier, plain ADD without).
        issue("mul", 64'd0, 64'd1, 64'd6, 64'd7, O_MUL, 2'b10, 1'b0, 6'b000001, 5'd10,
              mul_res, 1'b1);
        wait_mul("mul");
        tick();
        issue("mul_ovf", 64'd0, 64'd0, ALL1, 64'd2, O_MUL, 2'b10, 1'b0, 6'b000001, 5'd11,
              mul_ovf_res, 1'b1);
        wait_mul("mul_ovf");
        tick();
        tick();

        // Flush with a valid request pending: nothing accepted that cycle.
        pc_in     = '0;
        imm_in    = '0;
        rs1_in    = 64'd8;
        rs2_in    = 64'd8;
        opcode_in = O_ADD;
        alu_op_in = 2'b10;
        flush     = 1'b1;
        in_valid  = 1'b1;
        #1 check("flush.in_ready", 64'(in_ready), 64'd0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("flush.no_accept", 64'(out_valid), 64'd0);
        tick();

        // Flush drops a held result.
        out_ready = 1'b0;
        issue("fl_held", 64'd0, 64'd0, 64'd4, 64'd4, O_ADD, 2'b10, 1'b0, 6'b000001, 5'd2,
              64'd8, 1'b0);
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush.held_dropped", 64'(out_valid), 64'd0);
        tick();
        out_ready = 1'b1;

`ifdef EX_MUL_EN
        // Flush mid-MUL, then a fresh ADD must complete normally.
        issue("fl_mul", 64'd0, 64'd0, 64'd3, 64'd5, O_MUL, 2'b10, 1'b0, 6'b000001, 5'd12,
              64'd15, 1'b0);
        repeat (9) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        check("flush_mul.busy", 64'(busy), 64'd0);
        check("flush_mul.out_valid", 64'(out_valid), 64'd0);
        tick();
        issue("post_flush_add", 64'd0, 64'd0, 64'd1, 64'd1, O_ADD, 2'b10, 1'b0, 6'b000001,
              5'd13, 64'd2, 1'b1);
        @(negedge clk);
        check("post_flush_add.latency1", 64'(out_valid), 64'd1);
        repeat (70) tick();

        // Asynchronous reset in the middle of a MUL.
        issue("rst_mul", 64'd0, 64'd0, 64'd6, 64'd7, O_MUL, 2'b10, 1'b0, 6'b000001, 5'd14,
              64'd42, 1'b0);
        repeat (5) tick();
        #2 check("pre_rst.busy", 64'(busy), 64'd1);
`else
        // Asynchronous reset with a result held.
        out_ready = 1'b0;
        issue("rst_held", 64'd0, 64'd0, 64'd1, 64'd1, O_ADD, 2'b10, 1'b0, 6'b000001, 5'd14,
              64'd2, 1'b0);
        #2 check("pre_rst.out_valid", 64'(out_valid), 64'd1);
`endif
        rst_n = 1'b0;
        #1;
        check("async_rst.out_valid", 64'(out_valid), 64'd0);
        check("async_rst.busy", 64'(busy), 64'd0);
        check("async_rst.zero", 64'(zero), 64'd1);
        check("async_rst.alu_result", alu_result, 64'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;

        issue("post_rst", 64'h10, 64'd1, 64'd5, 64'd5, O_ADD, 2'b10, 1'b0, 6'b000001, 5'd15,
              64'd10, 1'b1);
        drained = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            #1;
            if (sb.size() == 0) begin
                drained = 1'b1;
                break;
            end
        end
        check("scoreboard_drained", 64'(drained), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
